operand_loader: RTL

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_pkg.sv | 16 +
 rtl/operand_loader_if.sv | 9 +
 rtl/operand_loader_shreg.sv | 15 +
 rtl/operand_loader.sv | 98 +++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared sizes, FSM state encoding and operand index encoding for operand_loader.
package operand_loader_pkg;
  localparam int OP_W = 1024;
  localparam int W = 32;
  localparam int NW = OP_W / W;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;
  localparam logic [2:0] OP_X = 3'd0;
  localparam logic [2:0] OP_M = 3'd1;
  localparam logic [2:0] OP_E = 3'd2;
  localparam logic [2:0] OP_R = 3'd3;
  localparam logic [2:0] OP_R2 = 3'd4;
  // Keep frames carry only x and e, so x is followed directly by e.
  function automatic logic [2:0] next_op(input logic [2:0] o, input logic keep);
    return (o == OP_X) ? (keep ? OP_E : OP_M) : (o == OP_M) ? OP_E : (o == OP_E) ? OP_R : OP_R2;
  endfunction
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: word stream into operand_loader (valid/ready handshake with end-of-frame marker).
interface operand_loader_if #(parameter int W = operand_loader_pkg::W);
  logic [W-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic s_last;
  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/operand_loader_shreg.sv
// operand_shreg: OP_W-bit register shifting one word in at the MSB end per enable; word 0 ends at the LSB.
module operand_shreg #(
    parameter int OP_W = operand_loader_pkg::OP_W,
    parameter int W = operand_loader_pkg::W
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic [W-1:0]    d,
    output logic [OP_W-1:0] q
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) q <= '0;
        else if (en) q <= {d, q[OP_W-1:W]};
endmodule

// File: rtl/operand_loader.sv
// operand_loader: collects a lene word plus x, m, e, r, r2 operands from a stream and starts the core.
// Optional OPERAND_LOADER_KEEP_MR_EN: lene bit 31 keeps previous m, r, r2 (frame carries x and e only).
module operand_loader import operand_loader_pkg::*; #(
    parameter int OP_W = operand_loader_pkg::OP_W,
    parameter int W = operand_loader_pkg::W
) (
    input  logic              clk,
    input  logic              resetn,
    operand_loader_if.slave   strm,
    output logic [OP_W-1:0]   out_x,
    output logic [OP_W-1:0]   out_m,
    output logic [OP_W-1:0]   out_e,
    output logic [OP_W-1:0]   out_r,
    output logic [OP_W-1:0]   out_r2,
    output logic [31:0]       out_lene,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              err
);
    localparam int NWL = OP_W / W;
    localparam int CW = $clog2(NWL);
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic keep;
    logic [31:0] lene_in;
    logic keep_in;
    logic [OP_W-1:0] opv [5];
`ifdef OPERAND_LOADER_KEEP_MR_EN
    assign lene_in = {1'b0, strm.s_data[30:0]};
    assign keep_in = strm.s_data[31];
`else
    assign lene_in = strm.s_data[31:0];
    assign keep_in = 1'b0;
`endif
    // s_ready is held low for the whole reset, not just after the first edge.
    assign strm.s_ready = resetn && (state == IDLE || state == LOAD || state == DRAIN);
    assign busy = state != IDLE;
    wire xfer = strm.s_valid && strm.s_ready;
    wire ld = xfer && state == LOAD;
    wire wrap = cnt == CW'(NWL - 1);
    wire last_word = wrap && op == (keep ? OP_E : OP_R2);
    wire lene_ok = out_lene != 32'd0 && out_lene <= 32'(OP_W);
    for (genvar g = 0; g < 5; g++) begin : g_op
        operand_shreg #(.OP_W(OP_W), .W(W)) u_sr (
            .clk(clk), .resetn(resetn), .en(ld && op == 3'(g)), .d(strm.s_data), .q(opv[g])
        );
    end
    assign out_x = opv[OP_X];
    assign out_m = opv[OP_M];
    assign out_e = opv[OP_E];
    assign out_r = opv[OP_R];
    assign out_r2 = opv[OP_R2];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            op <= OP_X;
            keep <= 1'b0;
            out_lene <= '0;
            core_start <= 1'b0;
            err <= 1'b0;
        end else begin
            core_start <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    out_lene <= lene_in;
                    keep <= keep_in;
                    cnt <= '0;
                    op <= OP_X;
                    err <= strm.s_last;
                    if (!strm.s_last) state <= LOAD;
                end
                LOAD: if (xfer) begin
                    if (last_word) begin
                        err <= !(strm.s_last && lene_ok);
                        core_start <= strm.s_last && lene_ok;
                        if (!strm.s_last) state <= DRAIN;
                        else if (lene_ok) state <= START;
                        else state <= IDLE;
                    end else if (strm.s_last) begin
                        err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= wrap ? '0 : cnt + 1'b1;
                        op <= wrap ? next_op(op, keep) : op;
                    end
                end
                START: state <= WAIT;
                WAIT: if (core_done) state <= IDLE;
                DRAIN: if (xfer && strm.s_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
